mole_gen: RTL and testbench

Game-sequencing stage that feeds the LED matrix scanner. Clocked once per mole period by `clk_half`, it:

- runs the game state machine (idle / play / win / lose);
- draws a new pseudo-random mole position each period;
- scores the previous mole as hit or missed.

Its `state`, `rowran` and `colran` outputs drive the scanner directly, and `hit` arrives from the keypad controller.

---
 rtl/mole_gen.sv | 182 ++++++++++++++++++
 tb/tb_mole_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mole_gen.sv
// -----------------------------------------------------------------------------
// mole_gen
//   Game-sequencing stage for the whack-a-mole LED matrix. It runs once per
//   mole period on clk_half and performs three jobs:
//     - runs the game state machine (IDLE / PLAY / WIN / LOSE);
//     - draws a pseudo-random mole position from an 8-bit LFSR each period;
//     - scores the mole that was just shown as a hit or a miss.
//
// Parameters
//   WIN_SCORE  hits needed to win (1..15)
//   MAX_MISS   misses that end the game (1..7)
//   LFSR_SEED  LFSR value after reset (nonzero)
//
// Ports
//   clk_half    in   1  mole-period clock, rising edge active
//   rst         in   1  synchronous, active-high reset
//   start       in   1  IDLE: begin a game; WIN/LOSE: return to IDLE
//   hit         in   1  current mole was struck this period (held to the edge)
//   rowran      out  3  mole row, 2..5 in PLAY, 0 otherwise
//   colran      out  3  mole column, 2..5 in PLAY, 0 otherwise
//   mole_valid  out  1  a mole is being presented (PLAY only)
//   state       out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
//   score       out  4  hits in the current or last game
//   misses      out  3  misses in the current or last game
// -----------------------------------------------------------------------------
module mole_gen #(
   parameter int unsigned WIN_SCORE = 10,
   parameter int unsigned MAX_MISS  = 5,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic       clk_half,
   input  logic       rst,
   input  logic       start,
   input  logic       hit,
   output logic [2:0] rowran,
   output logic [2:0] colran,
   output logic       mole_valid,
   output logic [1:0] state,
   output logic [3:0] score,
   output logic [2:0] misses
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_PLAY = 2'b01,
      S_WIN  = 2'b10,
      S_LOSE = 2'b11
   } state_t;

   localparam logic [3:0] WIN_SCORE_C = 4'(WIN_SCORE);
   localparam logic [2:0] MAX_MISS_C  = 3'(MAX_MISS);

   // 8-bit Fibonacci LFSR, taps 7/5/4/3, shifting left. The all-zero state is
   // a lock-up state for this structure, so it is escaped by reloading the seed.
   function automatic logic [7:0] lfsr_advance(input logic [7:0] l);
      logic [7:0] r;
      if (l == 8'h00) begin
         r = LFSR_SEED;
      end else begin
         r = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      return r;
   endfunction

   // Maps an LFSR value to a {row, col} mole position in 2..5.
   // With no_rep set, a candidate equal to the current position has its
   // column bumped by one (cyclic within 2..5) so the mole visibly moves.
   function automatic logic [5:0] place_mole(input logic [7:0] l,
                                             input logic       no_rep,
                                             input logic [2:0] cur_row,
                                             input logic [2:0] cur_col);
      logic [2:0] r;
      logic [2:0] c;
      logic [1:0] c_bump;
      r      = 3'd2 + {1'b0, l[1:0]};
      c      = 3'd2 + {1'b0, l[3:2]};
      c_bump = l[3:2] + 2'd1;
      if (no_rep && (r == cur_row) && (c == cur_col)) begin
         c = 3'd2 + {1'b0, c_bump};
      end
      return {r, c};
   endfunction

   state_t     state_p0;
   state_t     state_nxt;
   logic [7:0] lfsr_p0;
   logic [7:0] lfsr_nxt;
   logic [2:0] row_nxt;
   logic [2:0] col_nxt;
   logic [3:0] score_nxt;
   logic [2:0] misses_nxt;
   logic [3:0] score_inc;
   logic [2:0] misses_inc;
   logic [5:0] mole_first;
   logic [5:0] mole_next;

   assign lfsr_nxt   = lfsr_advance(lfsr_p0);
   assign score_inc  = score + 4'd1;
   assign misses_inc = misses + 3'd1;
   // The first mole of a game is never subject to the no-repeat rule.
   assign mole_first = place_mole(lfsr_nxt, 1'b0, rowran, colran);
   assign mole_next  = place_mole(lfsr_nxt, 1'b1, rowran, colran);

   // ---- state / output registers (all outputs registered) ----
   always_ff @(posedge clk_half) begin
      if (rst) begin
         state_p0   <= S_IDLE;
         lfsr_p0    <= LFSR_SEED;
         rowran     <= 3'd0;
         colran     <= 3'd0;
         mole_valid <= 1'b0;
         score      <= 4'd0;
         misses     <= 3'd0;
      end else begin
         state_p0   <= state_nxt;
         lfsr_p0    <= lfsr_nxt;
         rowran     <= row_nxt;
         colran     <= col_nxt;
         mole_valid <= (state_nxt == S_PLAY);
         score      <= score_nxt;
         misses     <= misses_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state_p0;
      unique case (state_p0)
         S_IDLE: begin
            if (start) state_nxt = S_PLAY;
         end
         S_PLAY: begin
            // Win takes precedence; only one counter moves per edge anyway.
            if (hit && (score_inc == WIN_SCORE_C)) begin
               state_nxt = S_WIN;
            end else if (!hit && (misses_inc == MAX_MISS_C)) begin
               state_nxt = S_LOSE;
            end
         end
         S_WIN, S_LOSE: begin
            if (start) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---- next values of the registered outputs ----
   always_comb begin
      row_nxt    = 3'd0;
      col_nxt    = 3'd0;
      score_nxt  = score;
      misses_nxt = misses;
      unique case (state_p0)
         S_IDLE: begin
            if (start) begin
               score_nxt  = 4'd0;
               misses_nxt = 3'd0;
               row_nxt    = mole_first[5:3];
               col_nxt    = mole_first[2:0];
            end
         end
         S_PLAY: begin
            if (hit) begin
               score_nxt = score_inc;
            end else begin
               misses_nxt = misses_inc;
            end
            if (state_nxt == S_PLAY) begin
               row_nxt = mole_next[5:3];
               col_nxt = mole_next[2:0];
            end
         end
         default: begin
            row_nxt = 3'd0;
            col_nxt = 3'd0;
         end
      endcase
   end

   assign state = state_p0;

endmodule

// File: tb/tb_mole_gen.sv
module tb_mole_gen;

   logic       clk_half;
   logic       rst;
   logic       start;
   logic       hit;
   logic [2:0] rowran;
   logic [2:0] colran;
   logic       mole_valid;
   logic [1:0] state;
   logic [3:0] score;
   logic [2:0] misses;

   mole_gen #(
      .WIN_SCORE(10),
      .MAX_MISS (5),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clk_half  (clk_half),
      .rst       (rst),
      .start     (start),
      .hit       (hit),
      .rowran    (rowran),
      .colran    (colran),
      .mole_valid(mole_valid),
      .state     (state),
      .score     (score),
      .misses    (misses)
   );

   initial clk_half = 1'b0;
   always #5 clk_half = ~clk_half;

   typedef struct {
      logic [1:0] st;
      logic [2:0] row;
      logic [2:0] col;
      logic       v;
      logic [3:0] sc;
      logic [2:0] ms;
      logic [7:0] lf;
   } exp_t;

   exp_t q[$];

   int vectors;
   int miscompares;
   int repeats_seen;

   // reference model state
   logic [7:0] m_lfsr;
   int         m_state;
   int         m_row;
   int         m_col;
   int         m_score;
   int         m_miss;
   logic       m_rep;   // last load exercised the no-repeat rule
   int         m_prev_row;
   int         m_prev_col;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One edge of the reference model.
   task automatic model_edge(input logic r, input logic s, input logic h);
      logic [7:0] L;
      int cr, cc;
      m_rep      = 1'b0;
      m_prev_row = m_row;
      m_prev_col = m_col;
      if (r) begin
         m_lfsr = 8'hA5; m_state = 0; m_row = 0; m_col = 0; m_score = 0; m_miss = 0;
         return;
      end
      if (m_lfsr == 8'h00) L = 8'hA5;
      else L = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      m_lfsr = L;
      cr = 2 + (int'(L) % 4);
      cc = 2 + ((int'(L) / 4) % 4);
      case (m_state)
         0: if (s) begin
               m_state = 1; m_score = 0; m_miss = 0; m_row = cr; m_col = cc;
            end
         1: begin
               if (h) m_score++; else m_miss++;
               if (m_score == 10) begin
                  m_state = 2; m_row = 0; m_col = 0;
               end else if (m_miss == 5) begin
                  m_state = 3; m_row = 0; m_col = 0;
               end else begin
                  if (cr == m_row && cc == m_col) begin
                     cc = 2 + (((int'(L) / 4) + 1) % 4);
                     m_rep = 1'b1;
                  end
                  m_row = cr; m_col = cc;
               end
            end
         default: if (s) m_state = 0;
      endcase
   endtask

   // Drive one period, push the expectation, then compare after the edge.
   task automatic apply(input logic r, input logic s, input logic h);
      exp_t e;
      exp_t o;
      rst = r; start = s; hit = h;
      model_edge(r, s, h);
      e.st = 2'(m_state); e.row = 3'(m_row); e.col = 3'(m_col);
      e.v  = (m_state == 1); e.sc = 4'(m_score); e.ms = 3'(m_miss); e.lf = m_lfsr;
      q.push_back(e);
      @(posedge clk_half);
      #1;
      o = q.pop_front();
      chk("state",      {6'd0, state},      {6'd0, o.st});
      chk("rowran",     {5'd0, rowran},     {5'd0, o.row});
      chk("colran",     {5'd0, colran},     {5'd0, o.col});
      chk("mole_valid", {7'd0, mole_valid}, {7'd0, o.v});
      chk("score",      {4'd0, score},      {4'd0, o.sc});
      chk("misses",     {5'd0, misses},     {5'd0, o.ms});
      chk("lfsr",       dut.lfsr_p0,        o.lf);
      if (m_rep) begin
         repeats_seen++;
         chk("norepeat_row", {5'd0, rowran}, 8'(m_prev_row));
         chk("norepeat_col", {5'd0, colran},
             8'(2 + (((m_prev_col - 2) + 1) % 4)));
      end
   endtask

   initial begin
      vectors = 0; miscompares = 0; repeats_seen = 0;
      m_lfsr = 8'h00; m_state = 0; m_row = 0; m_col = 0; m_score = 0; m_miss = 0;
      m_rep = 1'b0; m_prev_row = 0; m_prev_col = 0;
      rst = 1'b1; start = 1'b0; hit = 1'b0;

      // reset state
      apply(1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b0, 1'b0);
      chk("reset_state", {6'd0, state}, 8'h00);
      chk("reset_score", {4'd0, score}, 8'h00);

      // scenario 1: first edge after reset starts the game
      apply(1'b0, 1'b1, 1'b0);
      chk("s1_lfsr", dut.lfsr_p0, 8'h4A);
      chk("s1_state", {6'd0, state}, 8'h01);
      chk("s1_row", {5'd0, rowran}, 8'd4);
      chk("s1_col", {5'd0, colran}, 8'd4);
      chk("s1_valid", {7'd0, mole_valid}, 8'd1);

      // scenario 2: hit
      apply(1'b0, 1'b0, 1'b1);
      chk("s2_lfsr", dut.lfsr_p0, 8'h95);
      chk("s2_score", {4'd0, score}, 8'd1);
      chk("s2_row", {5'd0, rowran}, 8'd3);
      chk("s2_col", {5'd0, colran}, 8'd3);

      // scenario 3: five misses -> LOSE, start -> IDLE, start -> PLAY
      for (int i = 1; i <= 5; i++) begin
         apply(1'b0, (i == 3), 1'b0);   // start in PLAY is ignored
         chk("s3_misses", {5'd0, misses}, 8'(i));
      end
      chk("s3_lose", {6'd0, state}, 8'h03);
      chk("s3_lose_row", {5'd0, rowran}, 8'd0);
      chk("s3_lose_valid", {7'd0, mole_valid}, 8'd0);
      apply(1'b0, 1'b0, 1'b1);          // frozen in LOSE
      apply(1'b0, 1'b1, 1'b0);
      chk("s3_idle", {6'd0, state}, 8'h00);
      chk("s3_idle_misses", {5'd0, misses}, 8'd5);
      apply(1'b0, 1'b1, 1'b0);
      chk("s3_play", {6'd0, state}, 8'h01);
      chk("s3_clear", {4'd0, score}, 8'd0);

      // scenario 4: ten hits -> WIN, further hits change nothing
      for (int i = 1; i <= 10; i++) begin
         apply(1'b0, 1'b0, 1'b1);
         chk("s4_score", {4'd0, score}, 8'(i));
      end
      chk("s4_win", {6'd0, state}, 8'h02);
      chk("s4_misses", {5'd0, misses}, 8'd0);
      for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b1);
      chk("s4_frozen", {4'd0, score}, 8'd10);
      apply(1'b0, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b0);

      // scenario 5: long mixed play; the model flags every no-repeat event
      for (int i = 0; i < 600; i++) begin
         logic s;
         logic h;
         h = 1'($urandom_range(0, 3) != 0);
         s = (m_state == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         apply(1'b0, s, h);
      end
      chk("s5_repeats_hit", 8'(repeats_seen > 0), 8'd1);

      // scenario 6: reset mid-PLAY with hit held
      if (m_state != 1) begin
         for (int i = 0; i < 3 && m_state != 1; i++) apply(1'b0, 1'b1, 1'b0);
      end
      apply(1'b0, 1'b0, 1'b1);
      apply(1'b1, 1'b0, 1'b1);
      chk("s6_state", {6'd0, state}, 8'h00);
      chk("s6_score", {4'd0, score}, 8'd0);
      chk("s6_lfsr", dut.lfsr_p0, 8'hA5);
      apply(1'b0, 1'b1, 1'b0);
      chk("s6_row", {5'd0, rowran}, 8'd4);
      chk("s6_col", {5'd0, colran}, 8'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Guard against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
